// File: rtl/reg_file_16x16_pkg.sv
// Shared constants and types for the 16x16 register bank.
//   DATA_W      : register width (fixed at 16 to match the downstream mux)
//   ADDR_W      : write-address width
//   NUM_REGS    : number of registers (2**ADDR_W)
//   REG_RST_VAL : value loaded by reset and by the clear walk
//   state_t     : clear-engine FSM state
package reg_file_16x16_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] REG_RST_VAL = 16'h0000;

    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/reg_file_16x16_decoder.sv
// decoder_4to16: one-hot address decode with enable.
//   en   : when low, sel is all zeros
//   addr : register index
//   sel  : one-hot select, bit addr set when en is high
module decoder_4to16
    import reg_file_16x16_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] sel
);
    always_comb begin
        sel = '0;
        if (en) sel[addr] = 1'b1;
    end
endmodule

// File: rtl/reg_file_16x16.sv
// reg_file_16x16: sixteen 16-bit registers with one write port and a
// sequential clear engine that zeroes one register per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   we/waddr/wdata : write port, honoured only while idle
//   clr        : start a clear walk (ignored while one is running)
//   busy       : high for the 16 cycles of a clear walk
//   wr_drop    : one-cycle pulse after a write refused during a walk
//   R0..R15    : registered contents, R<n> feeds downstream mux input I<n>
// Build option: define REGFILE_R0_ZERO_EN to hard-wire R0 to zero and
// silently discard writes to address 0 (no wr_drop for them).
module reg_file_16x16
    import reg_file_16x16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              busy,
    output logic              wr_drop,
    output logic [DATA_W-1:0] R0,  R1,  R2,  R3,
    output logic [DATA_W-1:0] R4,  R5,  R6,  R7,
    output logic [DATA_W-1:0] R8,  R9,  R10, R11,
    output logic [DATA_W-1:0] R12, R13, R14, R15
);
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    state_t                         state;
    logic [ADDR_W-1:0]              ptr;
    logic [NUM_REGS-1:0]            wr_sel;
    logic [NUM_REGS-1:0]            clr_sel;
    logic [NUM_REGS-1:0][DATA_W-1:0] q;
    logic                           wr_refused;

    // Writes only land while idle; the walk pointer gets its own decoder so
    // the two selects never compete for the address path.
    decoder_4to16 u_wr_dec (.en(we & ~busy), .addr(waddr), .sel(wr_sel));
    decoder_4to16 u_clr_dec (.en(busy),      .addr(ptr),   .sel(clr_sel));

    // With a hard-wired R0, address-0 writes are discarded without a pulse.
    assign wr_refused = we && !(R0_ZERO && (waddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            busy    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_drop <= 1'b0;
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    wr_drop <= wr_refused;
                    // ptr wraps 15->0 on the exit edge, leaving it at 0 for IDLE
                    ptr     <= ptr + 1'b1;
                    if (ptr == ADDR_W'(NUM_REGS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    wr_drop <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
        if (R0_ZERO && g == 0) begin : g_zero
            logic sel0_unused;
            assign sel0_unused = wr_sel[g] | clr_sel[g];
            assign q[g] = REG_RST_VAL;
        end else begin : g_ff
            logic [DATA_W-1:0] r;
            // Clear wins, but the two selects are never both set: writes are
            // gated off whenever the walk is active.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          r <= REG_RST_VAL;
                else if (clr_sel[g]) r <= REG_RST_VAL;
                else if (wr_sel[g])  r <= wdata;
            end
            assign q[g] = r;
        end
    end

    assign R0  = q[0];  assign R1  = q[1];  assign R2  = q[2];  assign R3  = q[3];
    assign R4  = q[4];  assign R5  = q[5];  assign R6  = q[6];  assign R7  = q[7];
    assign R8  = q[8];  assign R9  = q[9];  assign R10 = q[10]; assign R11 = q[11];
    assign R12 = q[12]; assign R13 = q[13]; assign R14 = q[14]; assign R15 = q[15];
endmodule
